// File: rtl/mips_muldiv32.sv
// Iterative MIPS HI/LO unit: 32-cycle shift-add multiply and restoring divide,
// with sign fix-up in a final FIX cycle and direct MTHI/MTLO writes.
module mips_muldiv32 #(
    parameter logic [2:0] OP_MULT  = 3'b001,
    parameter logic [2:0] OP_MULTU = 3'b010,
    parameter logic [2:0] OP_DIV   = 3'b011,
    parameter logic [2:0] OP_DIVU  = 3'b100,
    parameter logic [2:0] OP_MTHI  = 3'b101,
    parameter logic [2:0] OP_MTLO  = 3'b110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        DivZero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_div_q, is_div_d;
    logic        dz_op_q, dz_op_d;
    logic        done_q, done_d;
    logic        divzero_q, divzero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        signed_op;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum33;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [63:0] neg_acc;

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_lo_d  = neg_lo_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dz_op_d   = dz_op_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        signed_op = (op == OP_MULT) || (op == OP_DIV);
        mag_a     = (signed_op && A[31]) ? -A : A;
        mag_b     = (signed_op && B[31]) ? -B : B;
        sum33     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        shifted   = {acc_q[63:32], acc_q[31]};
        trial     = shifted - {1'b0, opb_q};
        neg_acc   = -acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {32'd0, mag_a};
                            opb_d     = mag_b;
                            neg_lo_d  = signed_op && (A[31] ^ B[31]);
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            dz_op_d   = 1'b0;
                            cnt_d     = 5'd0;
                            state_d   = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d     = {32'd0, mag_a};
                            opb_d     = mag_b;
                            neg_lo_d  = signed_op && (A[31] ^ B[31]);
                            neg_rem_d = signed_op && A[31];
                            is_div_d  = 1'b1;
                            dz_op_d   = (B == 32'd0);
                            cnt_d     = 5'd0;
                            state_d   = (B == 32'd0) ? FIX : DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = {sum33, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            DIV: begin
                if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
                else            acc_d = {shifted[31:0], acc_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    divzero_d = dz_op_q;
                    if (!dz_op_q) begin
                        lo_d = neg_lo_q  ? neg_acc[31:0] : acc_q[31:0];
                        hi_d = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
                    end
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? neg_acc : acc_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dz_op_q   <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_lo_q  <= neg_lo_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dz_op_q   <= dz_op_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign DivZero = divzero_q;

endmodule

// File: tb/tb_mips_muldiv32.sv
// Bench for mips_muldiv32: an arithmetic model with a cycle countdown is compared
// against the DUT every cycle, plus literal expectations for the key cases.
module tb_mips_muldiv32;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivZero;

    int          checks;
    int          errors;

    logic        exp_busy;
    logic        exp_done;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_dz;
    int          remaining;

    mips_muldiv32 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .HI      (HI),
        .LO      (LO),
        .DivZero (DivZero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // Model: results are plain arithmetic, timing is a countdown of cycles to done
    task automatic modelEdge();
        logic [63:0] prod;
        longint      sa, sb;
        exp_done = 1'b0;
        if (rst) begin
            exp_hi    = 32'd0;
            exp_lo    = 32'd0;
            exp_dz    = 1'b0;
            remaining = 0;
        end else if (remaining == 0) begin
            if (start) begin
                case (op)
                    OP_MULT: begin
                        sa = longint'($signed(A));
                        sb = longint'($signed(B));
                        prod = 64'(sa * sb);
                        pend_hi = prod[63:32];
                        pend_lo = prod[31:0];
                        pend_dz = exp_dz;
                        remaining = 33;
                    end
                    OP_MULTU: begin
                        prod = {32'd0, A} * {32'd0, B};
                        pend_hi = prod[63:32];
                        pend_lo = prod[31:0];
                        pend_dz = exp_dz;
                        remaining = 33;
                    end
                    OP_DIV, OP_DIVU: begin
                        if (B == 32'd0) begin
                            pend_hi = exp_hi;
                            pend_lo = exp_lo;
                            pend_dz = 1'b1;
                            remaining = 1;
                        end else begin
                            if (op == OP_DIV) begin
                                sa = longint'($signed(A));
                                sb = longint'($signed(B));
                            end else begin
                                sa = longint'({32'd0, A});
                                sb = longint'({32'd0, B});
                            end
                            prod = 64'(sa / sb);
                            pend_lo = prod[31:0];
                            prod = 64'(sa % sb);
                            pend_hi = prod[31:0];
                            pend_dz = 1'b0;
                            remaining = 33;
                        end
                    end
                    OP_MTHI: exp_hi = A;
                    OP_MTLO: exp_lo = A;
                    default: ;
                endcase
            end
        end else begin
            remaining--;
            if (remaining == 0) begin
                exp_done = 1'b1;
                exp_hi   = pend_hi;
                exp_lo   = pend_lo;
                exp_dz   = pend_dz;
            end
        end
        exp_busy = (remaining != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
        checkOutput("done", {31'd0, done}, {31'd0, exp_done});
        checkOutput("HI", HI, exp_hi);
        checkOutput("LO", LO, exp_lo);
        checkOutput("DivZero", {31'd0, DivZero}, {31'd0, exp_dz});
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = s;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
    endtask

    // Accepting edge counts as edge 1; lat is the edge after which done is seen
    task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        applyStimulus(1'b1, o, a, b);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int lat;
        int done_count;
        checks    = 0;
        errors    = 0;
        remaining = 0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        exp_dz    = 1'b0;
        pend_hi   = 32'd0;
        pend_lo   = 32'd0;
        pend_dz   = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        applyStimulus(1'b1, 3'b000, 32'hDEAD, 32'h1);
        applyStimulus(1'b1, 3'b111, 32'hBEEF, 32'h1);
        checkOutput("badop_busy", {31'd0, busy}, 32'd0);
        checkOutput("badop_hi", HI, 32'd0);

        runOp(OP_MULT, 32'hFFFFFFFF, 32'h00000002, lat);
        checkOutput("mult_latency", lat, 34);
        checkOutput("mult_hi", HI, 32'hFFFFFFFF);
        checkOutput("mult_lo", LO, 32'hFFFFFFFE);

        runOp(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, lat);
        checkOutput("multu_hi", HI, 32'h00000001);
        checkOutput("multu_lo", LO, 32'hFFFFFFFE);

        runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        checkOutput("multu_max_hi", HI, 32'hFFFFFFFE);
        checkOutput("multu_max_lo", LO, 32'h00000001);

        runOp(OP_MULT, 32'h12345678, 32'h9ABCDEF0, lat);

        runOp(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat);
        checkOutput("div_latency", lat, 34);
        checkOutput("div_lo", LO, 32'hFFFFFFFD);
        checkOutput("div_hi", HI, 32'hFFFFFFFF);

        runOp(OP_DIVU, 32'd7, 32'd2, lat);
        checkOutput("divu_lo", LO, 32'd3);
        checkOutput("divu_hi", HI, 32'd1);

        runOp(OP_DIV, 32'd100, 32'hFFFFFFF9, lat);
        checkOutput("div_negb_lo", LO, 32'hFFFFFFF2);
        checkOutput("div_negb_hi", HI, 32'd2);

        runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        checkOutput("div_ovf_lo", LO, 32'h80000000);
        checkOutput("div_ovf_hi", HI, 32'd0);

        applyStimulus(1'b1, OP_MTHI, 32'h1234, 32'd0);
        checkOutput("mthi_hi", HI, 32'h1234);
        runOp(OP_DIVU, 32'd55, 32'd0, lat);
        checkOutput("dz_latency", lat, 2);
        checkOutput("dz_hi", HI, 32'h1234);
        checkOutput("dz_lo", LO, 32'h80000000);
        checkOutput("dz_flag", {31'd0, DivZero}, 32'd1);

        tick();
        applyStimulus(1'b1, OP_MTLO, 32'hAB, 32'd0);
        checkOutput("mtlo_keeps_dz", {31'd0, DivZero}, 32'd1);

        // MULT request in the middle of a DIVU must be dropped
        done_count = 0;
        applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 8; i++) tick();
        start = 1'b1;
        op    = OP_MULT;
        A     = 32'd3;
        B     = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) done_count++;
        end
        checkOutput("ignored_done_count", done_count, 1);
        checkOutput("ignored_lo", LO, 32'd14);
        checkOutput("ignored_hi", HI, 32'd2);
        checkOutput("dz_cleared", {31'd0, DivZero}, 32'd0);

        // Reset part-way through a MULT aborts it without a result
        done_count = 0;
        applyStimulus(1'b1, OP_MULT, 32'd5, 32'd6);
        for (int i = 0; i < 18; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_hi", HI, 32'd0);
        checkOutput("abort_lo", LO, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) done_count++;
        end
        checkOutput("abort_no_done", done_count, 0);
        applyStimulus(1'b1, OP_MTLO, 32'h55, 32'd0);
        checkOutput("mtlo_lo", LO, 32'h55);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
